// File: rtl/sim_sequencer.sv
// -----------------------------------------------------------------------------
// SimSequencer: drives a simulated clock made of NUM_PHASES sub-cycle phases.
// A launched run advances one phase per clock until the number of completed
// cycles reaches a limit latched at launch. The run can be paused, single-stepped
// one phase at a time, resumed, or aborted back to IDLE.
//
// Ports
//   clk           : single clock, all logic on the rising edge
//   reset         : synchronous active-high reset
//   start         : launch from IDLE/DONE, resume from PAUSE
//   pause         : suspend a running simulation
//   step          : advance exactly one phase while paused
//   abort         : return to IDLE from any state
//   max_cycles    : cycle limit, latched only when a launch is accepted
//   state         : IDLE=00, RUN=01, PAUSE=10, DONE=11
//   current_cycle : number of completed simulated cycles
//   phase         : current phase, 0..NUM_PHASES-1
//   cycle_tick    : one-clock pulse on each cycle completion
//   done          : one-clock pulse on entry to DONE
// -----------------------------------------------------------------------------
module sim_sequencer #(
  parameter int CYCLE_WIDTH = 8,
  parameter int NUM_PHASES  = 4,
  parameter int PHASE_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   step,
  input  logic                   abort,
  input  logic [CYCLE_WIDTH-1:0] max_cycles,
  output logic [1:0]             state,
  output logic [CYCLE_WIDTH-1:0] current_cycle,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   cycle_tick,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = PHASE_WIDTH'(NUM_PHASES - 1);

  state_t                 r_state;
  logic [CYCLE_WIDTH-1:0] r_cycle;
  logic [PHASE_WIDTH-1:0] r_phase;
  logic [CYCLE_WIDTH-1:0] r_limit;
  logic                   r_cycleTick;
  logic                   r_done;

  logic [PHASE_WIDTH-1:0] w_advPhase;
  logic [CYCLE_WIDTH-1:0] w_advCycle;
  logic                   w_advTick;
  logic                   w_advDone;

  // Result of one phase advance from the current counters. The limit is
  // never zero while an advance can happen (RUN/PAUSE), and the cycle count
  // is always below the limit there, so the increment cannot wrap.
  always_comb begin
    w_advPhase = r_phase + PHASE_WIDTH'(1);
    w_advCycle = r_cycle;
    w_advTick  = 1'b0;
    w_advDone  = 1'b0;
    if (r_phase == LAST_PHASE) begin
      w_advPhase = '0;
      w_advCycle = r_cycle + CYCLE_WIDTH'(1);
      w_advTick  = 1'b1;
      w_advDone  = ((r_cycle + CYCLE_WIDTH'(1)) == r_limit);
    end
  end

  // Control FSM with registered outputs. Pulses default low every edge and
  // are raised only by the event that owns them. Priority of the controls is
  // reset, abort, then the per-state handling of start/pause/step.
  always_ff @(posedge clk) begin
    r_cycleTick <= 1'b0;
    r_done      <= 1'b0;
    if (reset) begin
      r_state <= IDLE;
      r_cycle <= '0;
      r_phase <= '0;
      r_limit <= '0;
    end else if (abort) begin
      r_state <= IDLE;
      r_cycle <= '0;
      r_phase <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_cycle <= '0;
            r_phase <= '0;
            r_limit <= max_cycles;
            if (max_cycles == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          // start is meaningless while running, so pause is honoured.
          if (pause) begin
            r_state <= PAUSE;
          end else begin
            r_phase     <= w_advPhase;
            r_cycle     <= w_advCycle;
            r_cycleTick <= w_advTick;
            if (w_advDone) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        PAUSE: begin
          // Resume wins over a simultaneous step: no advance on that edge.
          if (start) begin
            r_state <= RUN;
          end else if (step) begin
            r_phase     <= w_advPhase;
            r_cycle     <= w_advCycle;
            r_cycleTick <= w_advTick;
            if (w_advDone) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign state         = r_state;
  assign current_cycle = r_cycle;
  assign phase         = r_phase;
  assign cycle_tick    = r_cycleTick;
  assign done          = r_done;

endmodule

// File: doc/sim_sequencer.md
SIM_SEQUENCER -- requirements
Module: sim_sequencer

Interface
REQ-001 SHALL have parameter CYCLE_WIDTH, default 8: width of the cycle counter and of the cycle limit.
REQ-002 SHALL have parameter NUM_PHASES, default 4: sub-cycle phases per simulated cycle, legal range 1..2^PHASE_WIDTH.
REQ-003 SHALL have parameter PHASE_WIDTH, default 2: width of the phase output.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  launch from IDLE/DONE; resume from PAUSE.
REQ-007 pause  input  1  suspend a running simulation.
REQ-008 step  input  1  advance exactly one phase while paused.
REQ-009 abort  input  1  return to IDLE from any state.
REQ-010 max_cycles  input  CYCLE_WIDTH  cycle limit, sampled only on an accepted start from IDLE/DONE.
REQ-011 state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-012 current_cycle  output  CYCLE_WIDTH  completed-cycle count.
REQ-013 phase  output  PHASE_WIDTH  current phase, 0..NUM_PHASES-1.
REQ-014 cycle_tick  output  1  one-clock pulse on each cycle completion.
REQ-015 done  output  1  one-clock pulse on entry to DONE.

Function
REQ-016 Priority per edge SHALL be: reset > abort > start > pause > step > free-running advance.
REQ-017 Phase advance SHALL be: phase+1; at NUM_PHASES-1, phase wraps to 0, current_cycle increments, and cycle_tick=1 on the next clock.
REQ-018 Completion: when an advance brings current_cycle to the latched limit, state SHALL go DONE on that same edge, with done=1 and cycle_tick=1 together.
REQ-019 IDLE: start with max_cycles!=0 SHALL latch the limit, clear current_cycle and phase, and go RUN.
REQ-020 IDLE: start with max_cycles==0 SHALL go DONE directly with done=1, cycle_tick=0, and counters at 0.
REQ-021 RUN: each clock without pause SHALL perform one phase advance.
REQ-022 RUN: pause SHALL go PAUSE with no advance on that edge.
REQ-023 PAUSE: counters SHALL hold.
REQ-024 PAUSE: step SHALL perform one phase advance and stay PAUSE, unless completion per REQ-018 applies, which goes DONE.
REQ-025 PAUSE: start SHALL go RUN without clearing counters or relatching the limit; start and step together SHALL resume only, with no advance.
REQ-026 DONE: counters SHALL hold with current_cycle equal to the limit and phase=0.
REQ-027 DONE: start SHALL behave as REQ-019/REQ-020, relatching max_cycles.
REQ-028 Inputs not listed for a state SHALL be ignored; step in RUN and pause in PAUSE/IDLE/DONE SHALL have no effect.
REQ-029 abort SHALL go IDLE, clear current_cycle and phase, and hold cycle_tick=0 and done=0 on the following clock.
REQ-030 max_cycles=2^CYCLE_WIDTH-1 SHALL complete at the all-ones count; current_cycle SHALL never wrap to 0.
REQ-031 NUM_PHASES=1 SHALL make every advance a cycle completion, with phase constant at 0.
REQ-032 cycle_tick and done SHALL be registered and remain high for exactly one clock per event.

Reset
REQ-033 While reset is high at a rising edge, the block SHALL go to: state=IDLE, current_cycle=0, phase=0, cycle_tick=0, done=0, latched limit=0.
REQ-034 Reset mid-RUN or mid-PAUSE SHALL discard all progress, with no done pulse.
REQ-035 Reset SHALL have no effect between clock edges.

Verification (CYCLE_WIDTH=8, NUM_PHASES=4)
REQ-036 Basic run: start with max_cycles=3 -> RUN for 12 clocks, cycle_tick pulses at clocks 4, 8 and 12, done at clock 12, then state=11 and current_cycle=3.
REQ-037 Pause and step: run 5 clocks, pause, then 3 single-clock steps -> phase=0 and current_cycle=2 with state=10 throughout; start then resumes RUN.
REQ-038 Zero limit: start with max_cycles=0 -> state=11 and done=1 on the next clock, current_cycle=0.
REQ-039 Abort and restart: abort mid-RUN -> state=00 with counters 0; a subsequent start with max_cycles=2 completes after 8 clocks.
REQ-040 Max limit: start with max_cycles=255 -> DONE after 1020 clocks with current_cycle=255 and no wrap.
REQ-041 Simultaneous inputs: in PAUSE, start and step together -> RUN with no extra advance; reset asserted together with start -> IDLE.
